// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobe, 2-flop column sync, tick-based debounce of press and release.
// Optional KEYPAD_REPEAT_EN adds auto-repeat key_valid pulses while a key is held.
module keypad_scanner #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEB_TICKS    = 20,
   parameter int REPEAT_TICKS = 250
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [7:0] code,
   output logic       key_valid,
   output logic       key_down
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEB_TICKS + 1);
   localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEB_TICKS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if (SCAN_DIV < 2 || DEB_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
      $error("keypad_scanner: parameter out of legal range");
   end

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [3:0]      col_m_q, col_s_q;
   logic [3:0]      row_q, row_d;
   logic [7:0]      code_q, code_d;
   logic [7:0]      cand_q, cand_d;
   logic [CW-1:0]   deb_q, deb_d;
   logic [CW-1:0]   rel_q, rel_d;
   logic            kv_q, kv_d;
   logic            kd_q, kd_d;

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_TICKS + 1);
   localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_TICKS);
   logic [RW-1:0]   rpt_q, rpt_d, rpt_inc;
`endif

   logic            tick;
   logic [3:0]      col_low;
   logic            one_col;
   logic [3:0]      row_next;
   logic [CW-1:0]   deb_inc, rel_inc;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q <= SCAN;
         pre_q   <= '0;
         col_m_q <= 4'hF;
         col_s_q <= 4'hF;
         row_q   <= 4'b1110;
         code_q  <= 8'hFF;
         cand_q  <= 8'hFF;
         deb_q   <= '0;
         rel_q   <= '0;
         kv_q    <= 1'b0;
         kd_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         col_m_q <= col;
         col_s_q <= col_m_q;
         row_q   <= row_d;
         code_q  <= code_d;
         cand_q  <= cand_d;
         deb_q   <= deb_d;
         rel_q   <= rel_d;
         kv_q    <= kv_d;
         kd_q    <= kd_d;
`ifdef KEYPAD_REPEAT_EN
         rpt_q   <= rpt_d;
`endif
      end
   end

   always_comb begin
      tick     = (pre_q == PRE_MAX);
      pre_d    = tick ? '0 : pre_q + 1'b1;
      col_low  = ~col_s_q;
      // Two or more low columns is a ghosting pattern and counts as no key.
      one_col  = (col_low != 4'h0) && ((col_low & (col_low - 4'h1)) == 4'h0);
      row_next = {row_q[2:0], row_q[3]};
      deb_inc  = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
      rel_inc  = (rel_q == DEB_MAX) ? rel_q : rel_q + 1'b1;

      state_d  = state_q;
      row_d    = row_q;
      code_d   = code_q;
      cand_d   = cand_q;
      deb_d    = deb_q;
      rel_d    = rel_q;
      kv_d     = 1'b0;
      kd_d     = kd_q;
`ifdef KEYPAD_REPEAT_EN
      rpt_d    = rpt_q;
      rpt_inc  = rpt_q + 1'b1;
`endif

      if (tick) begin
         case (state_q)
            SCAN: begin
               if (one_col) begin
                  cand_d  = {col_s_q, row_q};
                  deb_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  row_d = row_next;
               end
            end
            DEBOUNCE: begin
               if ({col_s_q, row_q} == cand_q) begin
                  deb_d = deb_inc;
                  if (deb_inc == DEB_MAX) begin
                     state_d = PRESSED;
                     code_d  = cand_q;
                     kv_d    = 1'b1;
                     kd_d    = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                     rpt_d   = '0;
`endif
                  end
               end else begin
                  state_d = SCAN;
                  row_d   = row_next;
               end
            end
            PRESSED: begin
               if (col_s_q == 4'hF) begin
                  rel_d = CNT_ONE;
                  if (CNT_ONE == DEB_MAX) begin
                     state_d = SCAN;
                     kd_d    = 1'b0;
                     code_d  = 8'hFF;
                     row_d   = row_next;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  if (rpt_inc == RPT_MAX) begin
                     kv_d  = 1'b1;
                     rpt_d = '0;
                  end else begin
                     rpt_d = rpt_inc;
                  end
`endif
               end
            end
            RELEASE: begin
               if (col_s_q == 4'hF) begin
                  rel_d = rel_inc;
                  if (rel_inc == DEB_MAX) begin
                     state_d = SCAN;
                     kd_d    = 1'b0;
                     code_d  = 8'hFF;
                     row_d   = row_next;
                  end
               end else begin
                  state_d = PRESSED;
                  rel_d   = '0;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   assign row       = row_q;
   assign code      = code_q;
   assign key_valid = kv_q;
   assign key_down  = kd_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, meaning CLOCK_50 cycles per scan tick (1 kHz at 50 MHz); legal range is 2 or greater.
REQ-002 Parameter DEB_TICKS, default 20, meaning consecutive matching ticks for press/release acceptance; legal range is 1 or greater.
REQ-003 Parameter REPEAT_TICKS, default 250, meaning ticks between auto-repeat pulses; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 CLOCK_50  input  1  single system clock; all logic is on the rising edge.
REQ-005 resetn  input  1  reset; synchronous, active-low.
REQ-006 col  input  4  keypad column lines, active-low, pulled up, asynchronous.
REQ-007 row  output  4  keypad row drive, one-hot active-low.
REQ-008 code  output  8  {col_sampled[3:0], row_driven[3:0]}, the exact 8-bit key code the downstream 7-segment decoder consumes; 8'hFF means no key.
REQ-009 key_valid  output  1  one-cycle pulse on each accepted key press.
REQ-010 key_down  output  1  level, high while an accepted key is held.

Function
REQ-011 Input sync: col SHALL pass through a 2-flop synchronizer (col_s) before any use.
REQ-012 Prescaler: the counter SHALL count 0..SCAN_DIV-1 and wrap; tick is high for one cycle when count==SCAN_DIV-1.
REQ-013 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE; the FSM SHALL evaluate only on tick cycles, except reset.
REQ-014 SCAN behaviour on tick:
- col_s with exactly one zero bit -> capture cand={col_s,row}; clear deb_cnt; enter DEBOUNCE; row frozen.
- Otherwise -> rotate row 1110->1101->1011->0111->1110.
REQ-015 Ghosting: col_s with two or more zero bits SHALL be treated as no key.
REQ-016 DEBOUNCE behaviour on tick:
- {col_s,row}==cand -> deb_cnt+1.
- deb_cnt reaches DEB_TICKS -> enter PRESSED; code<=cand; key_valid=1 for one cycle; key_down=1.
- Mismatch -> SCAN; row advances to the next row; code unchanged.
REQ-017 PRESSED behaviour on tick: row held; col_s==4'hF -> enter RELEASE with rel_cnt=1; any other value -> stay.
REQ-018 RELEASE behaviour on tick:
- col_s==4'hF -> rel_cnt+1.
- rel_cnt reaches DEB_TICKS -> SCAN; key_down=0; code<=8'hFF; row advances.
- Any zero in col_s -> back to PRESSED; rel_cnt cleared; no new key_valid.
REQ-019 Latency: key_valid SHALL assert in the cycle after the DEB_TICKS-th matching tick following the capture tick.
REQ-020 Changing to a different key while in PRESSED/RELEASE SHALL NOT produce key_valid until a full release completes.
REQ-021 Counters SHALL saturate and never wrap in DEBOUNCE or RELEASE.

Reset
REQ-022 On a rising CLOCK_50 edge with resetn=0, the following SHALL load: row=4'b1110, code=8'hFF, key_valid=0, key_down=0, state=SCAN, prescaler=0, deb_cnt=0, rel_cnt=0, synchronizer flops=4'hF.
REQ-023 Reset SHALL override any state, including mid-debounce or mid-press; no key_valid is emitted during reset or on the cycle after release of reset.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN defined: in PRESSED, a repeat counter SHALL count ticks; every REPEAT_TICKS ticks it pulses key_valid for one cycle with code unchanged; the counter clears on entry to PRESSED and stays frozen in RELEASE.
REQ-025 Macro KEYPAD_REPEAT_EN undefined: there is exactly one key_valid per press, and no repeat counter logic is present.

Verification (SCAN_DIV=4, DEB_TICKS=3, REPEAT_TICKS=5)
REQ-026 Hold resetn=0 for 2 cycles then release, with col=4'hF -> row=1110, code=8'hFF, key_valid=0; row rotates every 4 clocks.
REQ-027 col=4'b1101 held while row=1011 -> row freezes; after 3 further matching ticks, key_valid pulses once and code=8'hDB, key_down=1.
REQ-028 col=4'b1101 with a glitch for 1 tick (1 tick low, then high) -> no key_valid; code stays 8'hFF; scanning resumes at the next row.
REQ-029 col=4'b1001 (two columns low) -> no capture, rows keep rotating, code=8'hFF.
REQ-030 Press accepted, then release bouncing (F, 1110, F, F, F) -> key_down drops only after 3 consecutive F ticks; code returns to 8'hFF; exactly one key_valid.
REQ-031 With KEYPAD_REPEAT_EN defined, key held for 12 ticks after acceptance -> 3 key_valid pulses in total (initial + 2 repeats), code constant; assert resetn=0 mid-hold -> all outputs return to reset values on the next edge.
